// File: rtl/cp0_pkg.sv
// Shared constants, state type and trap-mask helper for the CP0 responder.
package cp0_pkg;

   localparam logic [4:0] REG_COUNT  = 5'd9;
   localparam logic [4:0] REG_STATUS = 5'd12;
   localparam logic [4:0] REG_CAUSE  = 5'd13;
   localparam logic [4:0] REG_EPC    = 5'd14;

   localparam logic [4:0] EXC_SYSCALL = 5'b01000;
   localparam logic [4:0] EXC_BREAK   = 5'b01001;
   localparam logic [4:0] EXC_TEQ     = 5'b01101;

   localparam int ST_IE         = 0;
   localparam int ST_IM_SYSCALL = 1;
   localparam int ST_IM_BREAK   = 2;
   localparam int ST_IM_TEQ     = 3;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_REDIR = 1'b1
   } cp0_state_e;

   // Codes without a dedicated mask bit are gated by IE alone.
   function automatic logic trap_ok(input logic [31:0] status, input logic [4:0] code);
      logic mask_ok;
      case (code)
         EXC_SYSCALL: mask_ok = status[ST_IM_SYSCALL];
         EXC_BREAK:   mask_ok = status[ST_IM_BREAK];
         EXC_TEQ:     mask_ok = status[ST_IM_TEQ];
         default:     mask_ok = 1'b1;
      endcase
      return status[ST_IE] & mask_ok;
   endfunction

endpackage

// File: rtl/cp0_if.sv
// Request/response bundle between the instruction controller and CP0.
interface cp0_if;
   logic        beat;
   logic [31:0] pc_in;
   logic        mfc0;
   logic        mtc0;
   logic        eret;
   logic        exception;
   logic [4:0]  cause;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] status;
   logic [31:0] exc_addr;
   logic        pc_redirect;
   logic        exc_taken;

   modport master (
      output beat, pc_in, mfc0, mtc0, eret, exception, cause, addr, wdata,
      input  rdata, status, exc_addr, pc_redirect, exc_taken
   );

   modport slave (
      input  beat, pc_in, mfc0, mtc0, eret, exception, cause, addr, wdata,
      output rdata, status, exc_addr, pc_redirect, exc_taken
   );
endinterface

// File: rtl/cp0_count.sv
// Free-running Count register; a software write replaces that cycle's increment.
module cp0_count (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        wr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] count_o
);
   logic [31:0] count_q, count_d;

   always_comb begin
      count_d = count_q + 32'd1;
      if (wr_i) count_d = wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;
endmodule

// File: rtl/cp0.sv
// CP0 responder: Status/Cause/EPC, trap/ERET redirect FSM. Optional Count via CP0_COUNT_EN.
//   state   | meaning
//   S_IDLE  | accepting requests on beat
//   S_REDIR | pc_redirect pulse cycle; all requests ignored
module cp0
   import cp0_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = 32'h0040_0004,
   parameter logic [31:0] STATUS_RST   = 32'h0000_0000
) (
   input  logic clk,
   input  logic reset,
   cp0_if.slave bus
);
   cp0_state_e  state_q, state_d;
   logic [31:0] status_q, status_d;
   logic [4:0]  cause_q, cause_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] exc_addr_q, exc_addr_d;
   logic        exc_taken_q, exc_taken_d;
   logic [31:0] count;
   logic        act, take_trap, do_eret, do_mtc0;
   logic        pc_redirect;
   logic [31:0] rdata;

   assign act       = bus.beat & (state_q == S_IDLE);
   assign take_trap = act & bus.exception & trap_ok(status_q, bus.cause);
   assign do_eret   = act & bus.eret & ~take_trap;
   assign do_mtc0   = act & bus.mtc0 & ~take_trap & ~do_eret;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (take_trap || do_eret) state_d = S_REDIR;
         S_REDIR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pc_redirect = (state_q == S_REDIR);
   end

   always_comb begin
      status_d    = status_q;
      cause_d     = cause_q;
      epc_d       = epc_q;
      exc_addr_d  = exc_addr_q;
      exc_taken_d = 1'b0;
      if (take_trap) begin
         epc_d       = bus.pc_in;
         cause_d     = bus.cause;
         status_d    = {status_q[26:0], 5'b0};
         exc_addr_d  = HANDLER_ADDR;
         exc_taken_d = 1'b1;
      end else if (do_eret) begin
         status_d   = {5'b0, status_q[31:5]};
         exc_addr_d = epc_q;
      end else if (do_mtc0) begin
         case (bus.addr)
            REG_STATUS: status_d = bus.wdata;
            REG_CAUSE:  cause_d  = bus.wdata[6:2];
            REG_EPC:    epc_d    = bus.wdata;
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         status_q    <= STATUS_RST;
         cause_q     <= '0;
         epc_q       <= '0;
         exc_addr_q  <= '0;
         exc_taken_q <= 1'b0;
      end else begin
         status_q    <= status_d;
         cause_q     <= cause_d;
         epc_q       <= epc_d;
         exc_addr_q  <= exc_addr_d;
         exc_taken_q <= exc_taken_d;
      end
   end

`ifdef CP0_COUNT_EN
   cp0_count u_count (
      .clk_i   (clk),
      .reset_i (reset),
      .wr_i    (do_mtc0 && (bus.addr == REG_COUNT)),
      .wdata_i (bus.wdata),
      .count_o (count)
   );
`else
   assign count = '0;
`endif

   always_comb begin
      rdata = '0;
      if (bus.mfc0) begin
         case (bus.addr)
            REG_COUNT:  rdata = count;
            REG_STATUS: rdata = status_q;
            REG_CAUSE:  rdata = {25'b0, cause_q, 2'b0};
            REG_EPC:    rdata = epc_q;
            default:    rdata = '0;
         endcase
      end
   end

   assign bus.rdata       = rdata;
   assign bus.status      = status_q;
   assign bus.exc_addr    = exc_addr_q;
   assign bus.pc_redirect = pc_redirect;
   assign bus.exc_taken   = exc_taken_q;
endmodule

// File: tb/tb_cp0.sv
// Directed vector bench for cp0: one vector per clock, rdata checked before the edge, outputs after.
module tb_cp0;
   logic clk = 1'b0;
   logic reset;
   cp0_if cp0_bus ();

   cp0 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (cp0_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        beat, mfc0, mtc0, eret, exc;
      logic [4:0]  cause, addr;
      logic [31:0] wdata, pc;
      logic [31:0] rd;
      logic        redir, taken;
      logic [31:0] xaddr, st;
   } vec_t;

   vec_t vecs[$];
   int n_vec = 0;
   int n_err = 0;

`ifdef CP0_COUNT_EN
   localparam logic [31:0] CNT0 = 32'hFFFF_FFFE;
   localparam logic [31:0] CNT1 = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] CNT0 = 32'h0;
   localparam logic [31:0] CNT1 = 32'h0;
`endif

   task automatic add(input logic b, rd_en, wr_en, er, ex, input logic [4:0] c, a,
                      input logic [31:0] wd, pc, rd, input logic redir, taken,
                      input logic [31:0] xa, st);
      vec_t v;
      v.beat = b; v.mfc0 = rd_en; v.mtc0 = wr_en; v.eret = er; v.exc = ex;
      v.cause = c; v.addr = a; v.wdata = wd; v.pc = pc; v.rd = rd;
      v.redir = redir; v.taken = taken; v.xaddr = xa; v.st = st;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      cp0_bus.beat = 0; cp0_bus.mfc0 = 0; cp0_bus.mtc0 = 0; cp0_bus.eret = 0;
      cp0_bus.exception = 0; cp0_bus.cause = '0; cp0_bus.addr = '0;
      cp0_bus.wdata = '0; cp0_bus.pc_in = '0;
   endtask

   task automatic chk_out(input string tag, input logic redir, taken,
                          input logic [31:0] xa, st);
      chk({tag, " pc_redirect"}, {31'b0, cp0_bus.pc_redirect}, {31'b0, redir});
      chk({tag, " exc_taken"},   {31'b0, cp0_bus.exc_taken},   {31'b0, taken});
      chk({tag, " exc_addr"},    cp0_bus.exc_addr, xa);
      chk({tag, " status"},      cp0_bus.status,   st);
   endtask

   localparam logic [31:0] H = 32'h0040_0004;

   initial begin
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      cp0_bus.mfc0 = 1; cp0_bus.addr = 5'd12;
      #1;
      n_vec++;
      chk("reset rdata12", cp0_bus.rdata, 32'h0);
      chk_out("reset", 0, 0, 32'h0, 32'h0);
      idle_inputs();

      //  beat mfc mtc eret exc cause  addr   wdata          pc             rd           redir tk exc_addr      status
      add(0, 1, 0, 0, 0, 5'h00, 5'd12, 32'h0,         32'h0,         32'h0,         0, 0, 32'h0,         32'h0);
      add(1, 0, 1, 0, 0, 5'h00, 5'd12, 32'h0000_000F, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0000_000F);
      add(0, 1, 0, 0, 0, 5'h00, 5'd12, 32'h0,         32'h0,         32'h0000_000F, 0, 0, 32'h0,         32'h0000_000F);
      add(1, 0, 0, 0, 1, 5'h08, 5'd0,  32'h0,         32'h0040_0100, 32'h0,         1, 1, H,             32'h0000_01E0);
      add(1, 1, 0, 1, 0, 5'h00, 5'd13, 32'h0,         32'h0,         32'h0000_0020, 0, 0, H,             32'h0000_01E0);
      add(0, 1, 0, 0, 0, 5'h00, 5'd14, 32'h0,         32'h0,         32'h0040_0100, 0, 0, H,             32'h0000_01E0);
      add(1, 0, 0, 1, 0, 5'h00, 5'd0,  32'h0,         32'h0,         32'h0,         1, 0, 32'h0040_0100, 32'h0000_000F);
      add(1, 1, 1, 0, 0, 5'h00, 5'd14, 32'h1234_5678, 32'h0,         32'h0040_0100, 0, 0, 32'h0040_0100, 32'h0000_000F);
      add(0, 1, 0, 0, 0, 5'h00, 5'd14, 32'h0,         32'h0,         32'h0040_0100, 0, 0, 32'h0040_0100, 32'h0000_000F);
      // masked break
      add(1, 0, 1, 0, 0, 5'h00, 5'd12, 32'h0000_000B, 32'h0,         32'h0,         0, 0, 32'h0040_0100, 32'h0000_000B);
      add(1, 0, 0, 0, 1, 5'h09, 5'd0,  32'h0,         32'h0040_0200, 32'h0,         0, 0, 32'h0040_0100, 32'h0000_000B);
      add(0, 1, 0, 0, 0, 5'h00, 5'd14, 32'h0,         32'h0,         32'h0040_0100, 0, 0, 32'h0040_0100, 32'h0000_000B);
      add(0, 1, 0, 0, 0, 5'h00, 5'd13, 32'h0,         32'h0,         32'h0000_0020, 0, 0, 32'h0040_0100, 32'h0000_000B);
      // teq + eret + mtc0 EPC on one beat: trap wins
      add(1, 0, 1, 1, 1, 5'h0D, 5'd14, 32'hAAAA_5555, 32'h0040_0300, 32'h0,         1, 1, H,             32'h0000_0160);
      add(0, 1, 0, 0, 0, 5'h00, 5'd14, 32'h0,         32'h0,         32'h0040_0300, 0, 0, H,             32'h0000_0160);
      add(0, 1, 0, 0, 0, 5'h00, 5'd13, 32'h0,         32'h0,         32'h0000_0034, 0, 0, H,             32'h0000_0160);
      add(1, 1, 1, 0, 0, 5'h00, 5'd5,  32'hFFFF_FFFF, 32'h0,         32'h0,         0, 0, H,             32'h0000_0160);
      // unmasked code, then IE=0 rejections
      add(1, 0, 1, 0, 0, 5'h00, 5'd12, 32'h0000_0001, 32'h0,         32'h0,         0, 0, H,             32'h0000_0001);
      add(1, 0, 0, 0, 1, 5'h0C, 5'd0,  32'h0,         32'h0040_0400, 32'h0,         1, 1, H,             32'h0000_0020);
      add(0, 1, 0, 0, 0, 5'h00, 5'd14, 32'h0,         32'h0,         32'h0040_0400, 0, 0, H,             32'h0000_0020);
      add(1, 0, 0, 0, 1, 5'h08, 5'd0,  32'h0,         32'h0040_0500, 32'h0,         0, 0, H,             32'h0000_0020);
      add(1, 0, 0, 0, 1, 5'h0C, 5'd0,  32'h0,         32'h0040_0500, 32'h0,         0, 0, H,             32'h0000_0020);
      // shift-out loss and zero refill
      add(1, 0, 1, 0, 0, 5'h00, 5'd12, 32'hFFFF_FFFF, 32'h0,         32'h0,         0, 0, H,             32'hFFFF_FFFF);
      add(1, 0, 0, 0, 1, 5'h0C, 5'd0,  32'h0,         32'h0000_0500, 32'h0,         1, 1, H,             32'hFFFF_FFE0);
      add(0, 0, 0, 0, 0, 5'h00, 5'd0,  32'h0,         32'h0,         32'h0,         0, 0, H,             32'hFFFF_FFE0);
      add(1, 0, 0, 1, 0, 5'h00, 5'd0,  32'h0,         32'h0,         32'h0,         1, 0, 32'h0000_0500, 32'h07FF_FFFF);
      add(0, 0, 0, 0, 0, 5'h00, 5'd0,  32'h0,         32'h0,         32'h0,         0, 0, 32'h0000_0500, 32'h07FF_FFFF);
      // Count wrap (reads 0 when Count is not built)
      add(1, 0, 1, 0, 0, 5'h00, 5'd9,  32'hFFFF_FFFE, 32'h0,         32'h0,         0, 0, 32'h0000_0500, 32'h07FF_FFFF);
      add(0, 1, 0, 0, 0, 5'h00, 5'd9,  32'h0,         32'h0,         CNT0,          0, 0, 32'h0000_0500, 32'h07FF_FFFF);
      add(0, 1, 0, 0, 0, 5'h00, 5'd9,  32'h0,         32'h0,         CNT1,          0, 0, 32'h0000_0500, 32'h07FF_FFFF);
      add(0, 1, 0, 0, 0, 5'h00, 5'd9,  32'h0,         32'h0,         32'h0,         0, 0, 32'h0000_0500, 32'h07FF_FFFF);
      // requests without beat do nothing
      add(0, 0, 1, 0, 0, 5'h00, 5'd12, 32'h0000_0055, 32'h0,         32'h0,         0, 0, 32'h0000_0500, 32'h07FF_FFFF);
      add(0, 0, 0, 1, 1, 5'h0C, 5'd0,  32'h0,         32'h0000_0600, 32'h0,         0, 0, 32'h0000_0500, 32'h07FF_FFFF);

      for (int i = 0; i < vecs.size(); i++) begin
         cp0_bus.beat = vecs[i].beat;   cp0_bus.mfc0 = vecs[i].mfc0;
         cp0_bus.mtc0 = vecs[i].mtc0;   cp0_bus.eret = vecs[i].eret;
         cp0_bus.exception = vecs[i].exc;
         cp0_bus.cause = vecs[i].cause; cp0_bus.addr = vecs[i].addr;
         cp0_bus.wdata = vecs[i].wdata; cp0_bus.pc_in = vecs[i].pc;
         #1;
         chk($sformatf("v%0d rdata", i), cp0_bus.rdata, vecs[i].rd);
         @(posedge clk);
         #1;
         n_vec++;
         chk_out($sformatf("v%0d", i), vecs[i].redir, vecs[i].taken, vecs[i].xaddr, vecs[i].st);
      end

      // reset landing in the REDIR cycle clears everything on the next edge
      idle_inputs();
      cp0_bus.beat = 1; cp0_bus.mtc0 = 1; cp0_bus.addr = 5'd12; cp0_bus.wdata = 32'h1;
      @(posedge clk); #1;
      idle_inputs();
      cp0_bus.beat = 1; cp0_bus.exception = 1; cp0_bus.cause = 5'h0C; cp0_bus.pc_in = 32'h0000_0700;
      @(posedge clk); #1;
      idle_inputs();
      n_vec++;
      chk_out("pre-reset", 1, 1, H, 32'h0000_0020);
      reset = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      chk_out("reset in redir", 0, 0, 32'h0, 32'h0);
      reset = 1'b0;
      cp0_bus.mfc0 = 1; cp0_bus.addr = 5'd14;
      #1;
      chk("reset epc", cp0_bus.rdata, 32'h0);
      cp0_bus.addr = 5'd13;
      #1;
      chk("reset cause", cp0_bus.rdata, 32'h0);
      idle_inputs();
      @(posedge clk); #1;
      n_vec++;
      chk_out("post reset idle", 0, 0, 32'h0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
